// File: rtl/fetch_decode_fifo_if.sv
// Shared entry type and the fetch/decode handshake bundle for fetch_decode_fifo.
// Fetch and decode drive the master side, and the FIFO is the slave side.
`ifndef FETCH_DECODE_FIFO_SIZE
`define FETCH_DECODE_FIFO_SIZE 16
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif

package fetch_decode_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_decode_pack_t;
endpackage

interface fetch_decode_fifo_if
    import fetch_decode_pkg::*;
#(
    parameter int DEPTH     = `FETCH_DECODE_FIFO_SIZE,
    parameter int IN_WIDTH  = `FETCH_WIDTH,
    parameter int OUT_WIDTH = `DECODE_WIDTH
);
    fetch_decode_pack_t [0:IN_WIDTH-1]  fetch_decode_fifo_data_in;
    logic [IN_WIDTH-1:0]                fetch_decode_fifo_data_in_valid;
    logic                               fetch_decode_fifo_push;
    logic [IN_WIDTH-1:0]                fetch_decode_fifo_data_in_enable;
    fetch_decode_pack_t [0:OUT_WIDTH-1] fetch_decode_fifo_data_out;
    logic [OUT_WIDTH-1:0]               fetch_decode_fifo_data_out_valid;
    logic [OUT_WIDTH-1:0]               fetch_decode_fifo_data_pop_valid;
    logic                               fetch_decode_fifo_pop;
    logic                               fetch_decode_fifo_flush;
    logic [$clog2(DEPTH):0]             fetch_decode_fifo_count;

    modport master (
        output fetch_decode_fifo_data_in, fetch_decode_fifo_data_in_valid, fetch_decode_fifo_push,
        output fetch_decode_fifo_data_pop_valid, fetch_decode_fifo_pop, fetch_decode_fifo_flush,
        input  fetch_decode_fifo_data_in_enable, fetch_decode_fifo_data_out,
        input  fetch_decode_fifo_data_out_valid, fetch_decode_fifo_count
    );

    modport slave (
        input  fetch_decode_fifo_data_in, fetch_decode_fifo_data_in_valid, fetch_decode_fifo_push,
        input  fetch_decode_fifo_data_pop_valid, fetch_decode_fifo_pop, fetch_decode_fifo_flush,
        output fetch_decode_fifo_data_in_enable, fetch_decode_fifo_data_out,
        output fetch_decode_fifo_data_out_valid, fetch_decode_fifo_count
    );
endinterface

// File: rtl/fetch_decode_fifo.sv
// Multi-port circular FIFO between fetch and decode: up to IN_WIDTH pushes and
// OUT_WIDTH pops per cycle, with flush and an asynchronous pointer reset.
`ifndef FETCH_DECODE_FIFO_SIZE
`define FETCH_DECODE_FIFO_SIZE 16
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif

module fetch_decode_fifo
    import fetch_decode_pkg::*;
#(
    parameter int DEPTH     = `FETCH_DECODE_FIFO_SIZE,
    parameter int IN_WIDTH  = `FETCH_WIDTH,
    parameter int OUT_WIDTH = `DECODE_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    fetch_decode_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count;
    logic [PW-1:0] free_slots;
    logic [IN_WIDTH-1:0]  in_enable;
    logic [IN_WIDTH-1:0]  push_en;
    logic [OUT_WIDTH-1:0] out_valid;
    logic [OUT_WIDTH-1:0] pop_en;

    fetch_decode_pack_t mem [DEPTH];

    // Pointer difference modulo 2^PW; the wrap bit distinguishes full from empty.
    assign count      = wptr_q - rptr_q;
    assign free_slots = PW'(DEPTH) - count;

    genvar gi;
    generate
        for (gi = 0; gi < IN_WIDTH; gi++) begin : g_in
            assign in_enable[gi] = free_slots > PW'(gi);
            assign push_en[gi]   = bus.fetch_decode_fifo_push
                                 & bus.fetch_decode_fifo_data_in_valid[gi] & in_enable[gi];
        end
        for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_out
            assign out_valid[gi] = count > PW'(gi);
            assign pop_en[gi]    = bus.fetch_decode_fifo_pop
                                 & bus.fetch_decode_fifo_data_pop_valid[gi] & out_valid[gi];
            assign bus.fetch_decode_fifo_data_out[gi] = mem[AW'(rptr_q + PW'(gi))];
        end
    endgenerate

    assign bus.fetch_decode_fifo_data_in_enable = in_enable;
    assign bus.fetch_decode_fifo_data_out_valid = out_valid;
    assign bus.fetch_decode_fifo_count          = count;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (push_en[i]) wptr_d = wptr_d + PW'(1);
        end
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (pop_en[i]) rptr_d = rptr_d + PW'(1);
        end
        if (bus.fetch_decode_fifo_flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately unreset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (push_en[i]) mem[AW'(wptr_q + PW'(i))] <= bus.fetch_decode_fifo_data_in[i];
        end
    end
endmodule

// File: doc/fetch_decode_fifo.md
FETCH_DECODE_FIFO -- requirements
Module: fetch_decode_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default `FETCH_DECODE_FIFO_SIZE (16); power of two, >= 8.
REQ-002 The module SHALL have parameter IN_WIDTH, default `FETCH_WIDTH (4); number of push ports.
REQ-003 The module SHALL have parameter OUT_WIDTH, default `DECODE_WIDTH (4); number of pop ports.
REQ-004 clk  input  1  the module's only clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 fetch_decode_fifo_data_in  input  fetch_decode_pack_t[0:IN_WIDTH-1]  entries offered by fetch.
REQ-007 fetch_decode_fifo_data_in_valid  input  IN_WIDTH  per-port offer; thermometer from bit 0.
REQ-008 fetch_decode_fifo_push  input  1  commit the offered entries this cycle.
REQ-009 fetch_decode_fifo_data_in_enable  output  IN_WIDTH  per-port free-space grant.
REQ-010 fetch_decode_fifo_data_out  output  fetch_decode_pack_t[0:OUT_WIDTH-1]  oldest entries, port 0 oldest.
REQ-011 fetch_decode_fifo_data_out_valid  output  OUT_WIDTH  per-port entry present.
REQ-012 fetch_decode_fifo_data_pop_valid  input  OUT_WIDTH  per-port pop request from decode; thermometer from bit 0.
REQ-013 fetch_decode_fifo_pop  input  1  commit the requested pops this cycle.
REQ-014 fetch_decode_fifo_flush  input  1  discard all contents.
REQ-015 fetch_decode_fifo_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries with read and write pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit, and the index is the low bits modulo DEPTH.
REQ-017 count SHALL equal wptr - rptr, modulo 2^($clog2(DEPTH)+1); empty when count = 0, full when count = DEPTH.
REQ-018 data_out_valid[i] SHALL be 1 iff count > i; data_out[i] SHALL be storage[(rptr+i) mod DEPTH]; both combinational from registered state only.
REQ-019 data_out[i] SHALL be don't-care while data_out_valid[i] = 0.
REQ-020 data_in_enable[i] SHALL be 1 iff (DEPTH - count) > i, computed from registered state only; same-cycle pops SHALL NOT raise the grant.
REQ-021 Number pushed SHALL be popcount(data_in_valid & data_in_enable) when push = 1, else 0.
REQ-022 Pushed port i SHALL write storage[(wptr+i) mod DEPTH].
REQ-023 Number popped SHALL be popcount(data_pop_valid & data_out_valid) when pop = 1, else 0.
REQ-024 At each rising edge, wptr SHALL advance by the number pushed and rptr SHALL advance by the number popped, in the same cycle.
REQ-025 A simultaneous push and pop SHALL both take effect, and occupancy SHALL never exceed DEPTH nor go below 0.
REQ-026 Pointer wrap-around SHALL be seamless: a multi-port push or pop straddling index DEPTH-1 to 0 SHALL keep port order.
REQ-027 Push or pop ports whose grant or valid bit is 0 SHALL NOT modify state.
REQ-028 Non-thermometer data_in_valid or data_pop_valid SHALL be a protocol violation; behaviour is then unspecified, and the bench SHALL flag it.
REQ-029 flush = 1 at a rising edge SHALL set wptr = rptr = 0, regardless of push or pop in the same cycle.
REQ-030 The cycle after a flush, data_out_valid SHALL be 0 and data_in_enable SHALL be all ones.
REQ-031 Latency SHALL be one cycle: an entry pushed at edge N is visible on data_out from edge N onward.

Reset
REQ-032 While rst = 1, wptr and rptr SHALL be 0 asynchronously.
REQ-033 While rst = 1, data_out_valid SHALL be 0, count SHALL be 0, and data_in_enable SHALL be all ones.
REQ-034 Storage contents SHALL NOT be reset.
REQ-035 Assertion of rst mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-036 After rst deasserts, the first push SHALL be accepted at the next rising edge.

Verification
REQ-037 Reset, then push 3 entries with pc 0x100/0x104/0x108 -> next cycle data_out_valid = 4'b0111, data_out[0].pc = 0x100, count = 3.
REQ-038 Fill DEPTH=16 via 4-wide pushes -> after 4 pushes count = 16 and data_in_enable = 0; a further push is ignored and count stays 16.
REQ-039 count = 14, push 4 with pop 2 in the same cycle -> data_in_enable = 4'b0011, 2 pushed, 2 popped, count = 14.
REQ-040 rptr = wptr = 14, push 4 (pc 0x200..0x20C) -> entries land at indices 14, 15, 0, 1; data_out[0..3].pc = 0x200, 0x204, 0x208, 0x20C.
REQ-041 count = 5, flush with push and pop in the same cycle -> next cycle count = 0, data_out_valid = 0, data_in_enable = 4'b1111.
REQ-042 count = 7, async rst pulsed between edges -> count and data_out_valid become 0 before the next edge.
